fc_command_scheduler: RTL

FC_COMMAND_SCHEDULER -- requirements
Module: fc_command_scheduler

---
 rtl/fc_command_scheduler.sv | 128 ++++++++++++
 1 files changed

// File: rtl/fc_command_scheduler.sv
// Fast-command scheduler: bunch-slot aligned link_reset/buffer_clear/calib
// commands plus throttled, spacing-limited L1A issue with statistics counters.
module fc_command_scheduler #(
  parameter int unsigned BX_W  = 12,
  parameter int unsigned OCC_W = 8
) (
  input  logic             clk_bx,
  input  logic             reset_n,
  input  logic [BX_W-1:0]  bx_counter,
  input  logic             req_l1a_ext,
  input  logic             req_l1a_sw,
  input  logic             req_link_reset,
  input  logic             req_buffer_clear,
  input  logic             req_calib,
  input  logic [BX_W-1:0]  cmd_bx,
  input  logic [7:0]       calib_l1a_offset,
  input  logic [7:0]       min_l1a_spacing,
  input  logic [OCC_W-1:0] occupancy,
  input  logic [OCC_W-1:0] occ_limit,
  input  logic             enable,
  input  logic             cnt_clear,
  output logic             l1a,
  output logic             link_reset,
  output logic             buffer_clear,
  output logic             calib_pulse,
  output logic             busy,
  output logic [31:0]      l1a_count,
  output logic [15:0]      l1a_veto_count
);

  logic        pend_lr_q, pend_lr_d;
  logic        pend_bc_q, pend_bc_d;
  logic        pend_cal_q, pend_cal_d;
  logic [7:0]  dly_q, dly_d;
  logic [7:0]  sp_q, sp_d;
  logic        l1a_q, l1a_d;
  logic        link_reset_q, link_reset_d;
  logic        buffer_clear_q, buffer_clear_d;
  logic        calib_pulse_q, calib_pulse_d;
  logic        busy_q, busy_d;
  logic [31:0] l1a_count_q, l1a_count_d;
  logic [15:0] veto_q, veto_d;

  logic slot_match, eff_lr, eff_bc, eff_cal;
  logic issue_lr, issue_bc, issue_cal;
  logic cal_l1a, cand, accept;

  always_comb begin
    slot_match = (bx_counter == cmd_bx);
    eff_lr     = pend_lr_q  | req_link_reset;
    eff_bc     = pend_bc_q  | req_buffer_clear;
    eff_cal    = pend_cal_q | req_calib;

    issue_lr  = slot_match & eff_lr;
    issue_bc  = slot_match & ~eff_lr & eff_bc;
    issue_cal = slot_match & ~eff_lr & ~eff_bc & eff_cal;

    pend_lr_d  = eff_lr  & ~issue_lr;
    pend_bc_d  = eff_bc  & ~issue_bc;
    pend_cal_d = eff_cal & ~issue_cal;

    // A fresh calib issue restarts the delay, so the old countdown's L1A is suppressed
    if (issue_cal)          dly_d = calib_l1a_offset;
    else if (dly_q != 8'd0) dly_d = dly_q - 8'd1;
    else                    dly_d = 8'd0;
    cal_l1a = (dly_q == 8'd1) & ~issue_cal;

    cand   = req_l1a_ext | req_l1a_sw | cal_l1a;
    accept = cand & enable & (occupancy < occ_limit) & (sp_q <= 8'd1);

    if (accept)            sp_d = min_l1a_spacing;
    else if (sp_q != 8'd0) sp_d = sp_q - 8'd1;
    else                   sp_d = 8'd0;

    l1a_d          = accept;
    link_reset_d   = issue_lr;
    buffer_clear_d = issue_bc;
    calib_pulse_d  = issue_cal;
    busy_d         = (occupancy >= occ_limit) | (sp_q > 8'd1) | ~enable;

    if (cnt_clear)   l1a_count_d = '0;
    else if (accept) l1a_count_d = l1a_count_q + 32'd1;
    else             l1a_count_d = l1a_count_q;

    if (cnt_clear)                          veto_d = '0;
    else if (cand & ~accept & (veto_q != '1)) veto_d = veto_q + 16'd1;
    else                                    veto_d = veto_q;
  end

  always_ff @(posedge clk_bx or negedge reset_n) begin
    if (!reset_n) begin
      pend_lr_q      <= 1'b0;
      pend_bc_q      <= 1'b0;
      pend_cal_q     <= 1'b0;
      dly_q          <= '0;
      sp_q           <= '0;
      l1a_q          <= 1'b0;
      link_reset_q   <= 1'b0;
      buffer_clear_q <= 1'b0;
      calib_pulse_q  <= 1'b0;
      busy_q         <= 1'b0;
      l1a_count_q    <= '0;
      veto_q         <= '0;
    end else begin
      pend_lr_q      <= pend_lr_d;
      pend_bc_q      <= pend_bc_d;
      pend_cal_q     <= pend_cal_d;
      dly_q          <= dly_d;
      sp_q           <= sp_d;
      l1a_q          <= l1a_d;
      link_reset_q   <= link_reset_d;
      buffer_clear_q <= buffer_clear_d;
      calib_pulse_q  <= calib_pulse_d;
      busy_q         <= busy_d;
      l1a_count_q    <= l1a_count_d;
      veto_q         <= veto_d;
    end
  end

  assign l1a            = l1a_q;
  assign link_reset     = link_reset_q;
  assign buffer_clear   = buffer_clear_q;
  assign calib_pulse    = calib_pulse_q;
  assign busy           = busy_q;
  assign l1a_count      = l1a_count_q;
  assign l1a_veto_count = veto_q;

endmodule
